// File: rtl/branch_resolution_unit_if.sv
`default_nettype none
// branch_resolution_unit_if -- decode/execute-side bundle of the branch resolution unit.
// Rev 1.0
interface branch_resolution_unit_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
);
    localparam int QC_W = $clog2(DEPTH) + 1;

    logic              pred_valid;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic [31:0]       pred_target;
    logic              res_valid;
    logic              res_taken;
    logic              stall_decode;
    logic              mispredict;
    logic              redirect_valid;
    logic [31:0]       redirect_addr;
    logic              flush;
    logic              update_valid;
    logic [31:0]       update_addr;
    logic              update_taken;
    logic [QC_W-1:0]   queue_count;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;
    logic              res_underflow;

    modport master (
        output pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken,
        input  stall_decode, mispredict, redirect_valid, redirect_addr, flush,
               update_valid, update_addr, update_taken, queue_count,
               branch_count, mispredict_count, res_underflow
    );

    modport slave (
        input  pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken,
        output stall_decode, mispredict, redirect_valid, redirect_addr, flush,
               update_valid, update_addr, update_taken, queue_count,
               branch_count, mispredict_count, res_underflow
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolution_unit.sv
`default_nettype none
// branch_resolution_unit -- in-order prediction queue resolved against actual outcomes.
// Rev 1.0
module branch_resolution_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    branch_resolution_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [QC_W-1:0] FULL_CNT   = QC_W'(DEPTH);
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic        ent_taken_q [DEPTH];
    logic [31:0] ent_pc_q    [DEPTH];
    logic [31:0] ent_tgt_q   [DEPTH];

    state_t           state_q;
    logic [FC_W-1:0]  flush_cnt_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [QC_W-1:0]  count_q;
    logic [QC_W-1:0]  count_d;

    logic             mispredict_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_addr_q;
    logic             update_valid_q;
    logic [31:0]      update_addr_q;
    logic             update_taken_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;
    logic             underflow_q;

    logic        in_flush;
    logic        full;
    logic        empty;
    logic        do_pop;
    logic        do_push;
    logic        mis;
    logic        head_taken;
    logic [31:0] head_pc;
    logic [31:0] head_tgt;

    always_comb begin
        in_flush   = (state_q == ST_FLUSH);
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        head_taken = ent_taken_q[rd_ptr_q];
        head_pc    = ent_pc_q[rd_ptr_q];
        head_tgt   = ent_tgt_q[rd_ptr_q];
        do_pop     = bus.res_valid && !empty && !in_flush;
        // A pop on the same edge frees the slot, so a full queue still accepts a push.
        do_push    = bus.pred_valid && !in_flush && (!full || do_pop);
        mis        = do_pop && (bus.res_taken != head_taken);
        count_d    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_taken_q[wr_ptr_q] <= bus.pred_taken;
            ent_pc_q[wr_ptr_q]    <= bus.pred_pc;
            ent_tgt_q[wr_ptr_q]   <= bus.pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            mispredict_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            update_valid_q   <= 1'b0;
            update_addr_q    <= '0;
            update_taken_q   <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            underflow_q      <= 1'b0;
        end else begin
            mispredict_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            update_valid_q   <= 1'b0;
            update_addr_q    <= '0;
            update_taken_q   <= 1'b0;

            if (bus.res_valid && empty && !in_flush) begin
                underflow_q <= 1'b1;
            end

            if (do_pop) begin
                update_valid_q <= 1'b1;
                update_addr_q  <= head_pc;
                update_taken_q <= bus.res_taken;
                mispredict_q   <= mis;
                if (branch_cnt_q != '1) begin
                    branch_cnt_q <= branch_cnt_q + 1'b1;
                end
                if (mis) begin
                    redirect_valid_q <= 1'b1;
                    redirect_addr_q  <= bus.res_taken ? head_tgt : head_pc + 32'd4;
                    if (mispredict_cnt_q != '1) begin
                        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
                    end
                end
            end

            // Mispredict discards every in-flight entry, including one pushed this edge.
            if (mis) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (mis) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall_decode     = full;
    assign bus.flush            = in_flush;
    assign bus.queue_count      = count_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_addr    = redirect_addr_q;
    assign bus.update_valid     = update_valid_q;
    assign bus.update_addr      = update_addr_q;
    assign bus.update_taken     = update_taken_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;
    assign bus.res_underflow    = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolution_unit.sv
`default_nettype none
// tb_branch_resolution_unit -- directed vector table, saturation sequences and randomized traffic.
// Rev 1.0
module tb_branch_resolution_unit;
    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolution_unit_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

    branch_resolution_unit #(
        .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        bit          taken;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        bit pv; bit pt; logic [31:0] ppc; logic [31:0] ptgt; bit rv; bit rt;
        bit uv; logic [31:0] ua; bit ut; bit mp; bit rdv; logic [31:0] rda;
        bit fl; int qc; bit sd;
    } vec_t;

    ent_t        mq[$];
    int          m_flush_left, m_bc, m_mc;
    bit          m_uv, m_ut, m_mp, m_rdv, m_und;
    logic [31:0] m_ua, m_rda;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0; m_bc = 0; m_mc = 0;
        m_uv = 0; m_ut = 0; m_mp = 0; m_rdv = 0; m_und = 0;
        m_ua = '0; m_rda = '0;
    endtask

    // One rising edge of the reference behaviour, using the inputs held across it.
    task automatic model_edge();
        ent_t e;
        bit popping, pushing;
        m_uv = 0; m_ua = '0; m_ut = 0; m_mp = 0; m_rdv = 0; m_rda = '0;
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        popping = bus.res_valid && mq.size() > 0;
        pushing = bus.pred_valid && (mq.size() < DEPTH || popping);
        if (bus.res_valid && mq.size() == 0) m_und = 1;
        if (popping) begin
            e = mq.pop_front();
            m_uv = 1; m_ua = e.pc; m_ut = bus.res_taken;
            if (m_bc < CNT_MAX) m_bc++;
            if (bus.res_taken != e.taken) begin
                m_mp = 1; m_rdv = 1;
                m_rda = bus.res_taken ? e.tgt : e.pc + 32'd4;
                if (m_mc < CNT_MAX) m_mc++;
                mq.delete();
                pushing = 0;
                m_flush_left = FLUSH_CYCLES;
            end
        end
        if (pushing) mq.push_back('{bus.pred_taken, bus.pred_pc, bus.pred_target});
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".update_valid"},     bus.update_valid,     m_uv);
        chk({tag, ".update_addr"},      bus.update_addr,      m_ua);
        chk({tag, ".update_taken"},     bus.update_taken,     m_ut);
        chk({tag, ".mispredict"},       bus.mispredict,       m_mp);
        chk({tag, ".redirect_valid"},   bus.redirect_valid,   m_rdv);
        chk({tag, ".redirect_addr"},    bus.redirect_addr,    m_rda);
        chk({tag, ".flush"},            bus.flush,            m_flush_left > 0);
        chk({tag, ".queue_count"},      bus.queue_count,      mq.size());
        chk({tag, ".stall_decode"},     bus.stall_decode,     mq.size() == DEPTH);
        chk({tag, ".branch_count"},     bus.branch_count,     m_bc);
        chk({tag, ".mispredict_count"}, bus.mispredict_count, m_mc);
        chk({tag, ".res_underflow"},    bus.res_underflow,    m_und);
    endtask

    task automatic apply(input string tag, input bit pv, input bit pt, input logic [31:0] ppc,
                         input logic [31:0] ptgt, input bit rv, input bit rt);
        bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_pc = ppc; bus.pred_target = ptgt;
        bus.res_valid = rv; bus.res_taken = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic vec_t v(input bit pv, input bit pt, input logic [31:0] ppc,
                               input logic [31:0] ptgt, input bit rv, input bit rt,
                               input bit uv, input logic [31:0] ua, input bit ut, input bit mp,
                               input bit rdv, input logic [31:0] rda, input bit fl,
                               input int qc, input bit sd);
        vec_t r;
        r.pv = pv; r.pt = pt; r.ppc = ppc; r.ptgt = ptgt; r.rv = rv; r.rt = rt;
        r.uv = uv; r.ua = ua; r.ut = ut; r.mp = mp; r.rdv = rdv; r.rda = rda;
        r.fl = fl; r.qc = qc; r.sd = sd;
        return r;
    endfunction

    initial begin
        //          pv pt ppc     ptgt    rv rt  uv ua      ut mp rdv rda     fl qc sd
        tbl[0]  = v(1, 1, 'h100, 'h140, 0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 1, 0);
        tbl[1]  = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h100, 1, 0, 0, 'h0,   0, 0, 0);
        tbl[2]  = v(1, 0, 'h200, 'h280, 0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 1, 0);
        tbl[3]  = v(1, 0, 'h300, 'h380, 0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 2, 0);
        tbl[4]  = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h200, 1, 1, 1, 'h280, 1, 0, 0);
        tbl[5]  = v(1, 1, 'h500, 'h540, 0, 0,  0, 'h0,   0, 0, 0, 'h0,   1, 0, 0);
        tbl[6]  = v(0, 0, 'h0,   'h0,   0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 0, 0);
        tbl[7]  = v(1, 1, 'h400, 'h480, 0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 1, 0);
        tbl[8]  = v(0, 0, 'h0,   'h0,   1, 0,  1, 'h400, 0, 1, 1, 'h404, 1, 0, 0);
        tbl[9]  = v(0, 0, 'h0,   'h0,   1, 1,  0, 'h0,   0, 0, 0, 'h0,   1, 0, 0);
        tbl[10] = v(0, 0, 'h0,   'h0,   0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 0, 0);
        tbl[11] = v(1, 1, 'h10,  'h18,  0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 1, 0);
        tbl[12] = v(1, 1, 'h20,  'h28,  0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 2, 0);
        tbl[13] = v(1, 1, 'h30,  'h38,  0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 3, 0);
        tbl[14] = v(1, 1, 'h40,  'h48,  0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 4, 1);
        tbl[15] = v(1, 1, 'h50,  'h58,  0, 0,  0, 'h0,   0, 0, 0, 'h0,   0, 4, 1);
        tbl[16] = v(1, 1, 'h60,  'h68,  1, 1,  1, 'h10,  1, 0, 0, 'h0,   0, 4, 1);
        tbl[17] = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h20,  1, 0, 0, 'h0,   0, 3, 0);
        tbl[18] = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h30,  1, 0, 0, 'h0,   0, 2, 0);
        tbl[19] = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h40,  1, 0, 0, 'h0,   0, 1, 0);
        tbl[20] = v(0, 0, 'h0,   'h0,   1, 1,  1, 'h60,  1, 0, 0, 'h0,   0, 0, 0);
        tbl[21] = v(0, 0, 'h0,   'h0,   1, 1,  0, 'h0,   0, 0, 0, 'h0,   0, 0, 0);

        bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_pc = '0; bus.pred_target = '0;
        bus.res_valid = 0; bus.res_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        apply("post_reset", 0, 0, '0, '0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply(t, tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptgt, tbl[i].rv, tbl[i].rt);
            chk({t, ".tbl_uv"},  bus.update_valid,   tbl[i].uv);
            chk({t, ".tbl_ua"},  bus.update_addr,    tbl[i].ua);
            chk({t, ".tbl_ut"},  bus.update_taken,   tbl[i].ut);
            chk({t, ".tbl_mp"},  bus.mispredict,     tbl[i].mp);
            chk({t, ".tbl_rdv"}, bus.redirect_valid, tbl[i].rdv);
            chk({t, ".tbl_rda"}, bus.redirect_addr,  tbl[i].rda);
            chk({t, ".tbl_fl"},  bus.flush,          tbl[i].fl);
            chk({t, ".tbl_qc"},  bus.queue_count,    tbl[i].qc);
            chk({t, ".tbl_sd"},  bus.stall_decode,   tbl[i].sd);
        end
        chk("table_underflow", bus.res_underflow, 1);
        chk("table_branch_count", bus.branch_count, 8);
        chk("table_mispredict_count", bus.mispredict_count, 2);

        // Correct predictions until the branch counter pins at all-ones.
        for (int i = 0; i < 10; i++) begin
            apply("sat_bc_push", 1, 0, 32'h1000 + i * 4, 32'h2000, 0, 0);
            apply("sat_bc_pop", 0, 0, '0, '0, 1, 0);
        end
        chk("branch_count_saturated", bus.branch_count, CNT_MAX);

        // Mispredicts (each followed by its flush window) until that counter saturates too.
        for (int i = 0; i < 14; i++) begin
            apply("sat_mc_push", 1, 0, 32'h3000 + i * 4, 32'h3800, 0, 0);
            apply("sat_mc_pop", 0, 0, '0, '0, 1, 1);
            apply("sat_mc_fl0", 0, 0, '0, '0, 0, 0);
            apply("sat_mc_fl1", 0, 0, '0, '0, 0, 0);
        end
        chk("mispredict_count_saturated", bus.mispredict_count, CNT_MAX);
        chk("branch_count_held", bus.branch_count, CNT_MAX);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            if (i == 300) begin
                #2 reset_n = 1'b0;
                #1;
                model_reset();
                chk("midreset_queue_count", bus.queue_count, 0);
                chk("midreset_update_valid", bus.update_valid, 0);
                chk("midreset_flush", bus.flush, 0);
                chk("midreset_branch_count", bus.branch_count, 0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            apply("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pc, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
